// File: rtl/serial_ha_adder.sv
// Bit-serial adder controller: feeds an external half-adder cell one bit pair per cycle
// (LSB first) and completes each bit with an internal second half-adder stage plus carry flop.
module serial_ha_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ha_x,
    output logic             ha_y,
    input  logic             ha_sum,
    input  logic             ha_carry,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               bit_c;
    logic               carry_next_c;

    // Second half-adder stage folds the running carry into the cell's result
    assign bit_c        = ha_sum ^ carry_q;
    assign carry_next_c = ha_carry | (ha_sum & carry_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = b;
                    sum_d   = '0;
                    cnt_d   = '0;
                    carry_d = 1'b0;
                    cout_d  = 1'b0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sum_d   = {bit_c, sum_q[WIDTH-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = carry_next_c;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    cout_d  = carry_next_c;
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand bits reach the cell only while an add is running
    assign ha_x = (state_q == RUN) & a_q[0];
    assign ha_y = (state_q == RUN) & b_q[0];

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_ha_adder.sv
// Self-checking bench for serial_ha_adder: arithmetic reference model, per-cycle compare,
// directed literal cases and randomized adds.
module tb_serial_ha_adder;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         ha_x, ha_y, ha_sum, ha_carry;
    logic         busy, done, cout;
    logic [W-1:0] sum;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int done_cnt = 0;
    bit chk_en   = 1'b0;

    // Reference model state: phase 0 idle, 1..W = RUN cycle (phase-1 bits done), W+1 = done cycle
    int           m_phase = 0;
    logic [W-1:0] m_a = '0, m_b = '0, m_sum = '0;
    logic         m_cout = 1'b0;

    serial_ha_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .ha_x(ha_x), .ha_y(ha_y), .ha_sum(ha_sum), .ha_carry(ha_carry),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    // The team's half-adder cell
    assign ha_sum   = ha_x ^ ha_y;
    assign ha_carry = ha_x & ha_y;

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_phase = 0; m_sum = '0; m_cout = 1'b0; m_a = '0; m_b = '0;
        end else if ((m_phase == 0 || m_phase == W + 1) && start) begin
            m_phase = 1; m_a = a; m_b = b; m_sum = '0; m_cout = 1'b0;
        end else if (m_phase >= 1 && m_phase < W) begin
            m_phase++;
        end else if (m_phase == W) begin
            m_phase = W + 1;
            {m_cout, m_sum} = (W+1)'(m_a) + (W+1)'(m_b);
        end else begin
            m_phase = 0;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            int k, t;
            if (done) done_cnt++;
            check("busy", int'(busy), int'(m_phase >= 1 && m_phase <= W));
            check("done", int'(done), int'(m_phase == W + 1));
            if (m_phase >= 1 && m_phase <= W) begin
                k = m_phase - 1;
                t = int'(m_a) + int'(m_b);
                check("ha_x", int'(ha_x), int'(m_a[k]));
                check("ha_y", int'(ha_y), int'(m_b[k]));
                check("partial_sum", int'(sum), (t & ((1 << k) - 1)) << (W - k));
            end else begin
                check("ha_x_idle", int'(ha_x), 0);
                check("ha_y_idle", int'(ha_y), 0);
                check("sum", int'(sum), int'(m_sum));
                check("cout", int'(cout), int'(m_cout));
            end
        end
    end

    task automatic do_add(input logic [W-1:0] av, input logic [W-1:0] bv);
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int at);
        at = -1;
        for (int i = 0; i < 30; i++) begin
            if (done) begin
                at = cyc;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (at < 0) begin
            failures++;
            $display("FAIL wait_done: no done pulse within 30 cycles at cycle %0d", cyc);
        end
    endtask

    task automatic add_and_pin(input logic [W-1:0] av, input logic [W-1:0] bv,
                               input int exp_sum, input int exp_cout);
        int t;
        do_add(av, bv);
        wait_done(t);
        check("lit_sum", int'(sum), exp_sum);
        check("lit_cout", int'(cout), exp_cout);
    endtask

    initial begin
        int t1, t2, dc;
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_sum", int'(sum), 0);
        check("rst_cout", int'(cout), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        chk_en = 1'b1;

        add_and_pin(8'h5A, 8'h33, 8'h8D, 0);
        add_and_pin(8'hFF, 8'h01, 8'h00, 1);
        add_and_pin(8'hFF, 8'hFF, 8'hFE, 1);
        add_and_pin(8'h00, 8'h00, 8'h00, 0);

        // start re-pulsed mid-RUN must be ignored
        do_add(8'h10, 8'h20);
        repeat (3) @(negedge clk);
        a = 8'h01; b = 8'h01; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dc = done_cnt;
        wait_done(t1);
        check("ignore_sum", int'(sum), 8'h30);
        check("ignore_cout", int'(cout), 0);
        repeat (12) @(negedge clk);
        check("single_done", done_cnt - dc, 1);

        // reset at RUN cycle 4 aborts with no done
        do_add(8'hAB, 8'hCD);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_sum", int'(sum), 0);
        check("abort_cout", int'(cout), 0);
        dc = done_cnt;
        repeat (12) @(negedge clk);
        check("abort_no_done", done_cnt - dc, 0);

        // start held through DONE: back-to-back adds
        @(negedge clk);
        a = 8'h12; b = 8'h34; start = 1'b1;
        @(negedge clk);
        wait_done(t1);
        check("b2b_sum1", int'(sum), 8'h46);
        check("b2b_cout1", int'(cout), 0);
        a = 8'hC0; b = 8'h50;
        @(negedge clk);
        start = 1'b0;
        wait_done(t2);
        check("b2b_spacing", t2 - t1, 9);
        check("b2b_sum2", int'(sum), 8'h10);
        check("b2b_cout2", int'(cout), 1);

        // Randomized adds, sometimes with stray start pulses or idle gaps
        for (int n = 0; n < 40; n++) begin
            do_add(W'($urandom), W'($urandom));
            repeat ($urandom_range(0, 6)) @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                a = W'($urandom); b = W'($urandom); start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            wait_done(t1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
